operand_fetch: RTL
==================

Name: operand_fetch

Overview:
Pipeline stage between decode and execute that reads operands from the register file. It presents rs1/rs2 to the register file's synchronous read port and holds the instruction through the file's one-cycle read latency. It bypasses results still in flight from EX, MEM and WB, and detects load-use hazards. Operands reach execute over a valid/ready handshake.

Parameters:
XLEN, 32, operand/data width
RA_W, 5, register address width
PC_W, 32, pass-through PC width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous kill of held instruction
in_valid  in  1  decode has an instruction
in_ready  out  1  stage can accept
in_pc  in  PC_W  instruction PC
in_rs1, in_rs2, in_rd  in  RA_W  register indices
in_use1, in_use2  in  1  instruction reads rs1/rs2
rf_rs1, rf_rs2  out  RA_W  register-file read addresses
rf_r1, rf_r2  in  XLEN  register-file read data (registered, write-through)
ex_valid, ex_is_load  in  1  EX-stage producer valid / is a load
ex_rd  in  RA_W; ex_data  in  XLEN  EX result
mem_valid  in  1; mem_rd  in  RA_W; mem_data  in  XLEN  MEM result
wb_valid  in  1; wb_rd  in  RA_W; wb_data  in  XLEN  same signals as the register-file write port
out_valid  out  1; out_ready  in  1  handshake to execute
out_pc  out  PC_W; out_rd  out  RA_W  pass-through
out_op1, out_op2  out  XLEN  resolved operands
stall_cnt  out  32  saturating count of load-use stall cycles

Behaviour:
- Reset (async, rst_n=0): state EMPTY, held fields 0, out_valid=0, in_ready=1, stall_cnt=0, rf_rs1/rf_rs2=0.
- States:
  - EMPTY: no instruction held.
  - FULL: instruction held, no hazard.
  - STALL: instruction held, load-use hazard.
- Accept: in_valid && in_ready at an edge latches pc/rs1/rs2/rd/use flags.
- in_ready = EMPTY || (out_valid && out_ready), so back-to-back throughput is 1 per cycle.
- rf_rs1 = in_ready ? in_rs1 : held_rs1 (combinational); rf_rs2 likewise. The register file samples the address on the same edge that accepts the instruction, so rf_r1/rf_r2 are valid in the next cycle.
- Latency: accept at edge N, out_valid may rise in cycle N+1.
- While holding, the held address is re-presented every cycle, so rf_r1/rf_r2 track register-file writes.
- Operand resolution per source s (combinational from held index h):
  - h==0 -> 0; x0 is never forwarded.
  - else EX match (ex_valid, ex_rd==h, !ex_is_load) -> ex_data.
  - else MEM match -> mem_data.
  - else WB match -> wb_data.
  - else rf value.
  - Youngest producer wins.
- Hazard = (in_use1 && h1!=0 && ex_valid && ex_is_load && ex_rd==h1), or the same condition for rs2 with in_use2.
- out_valid = (FULL or STALL) && !hazard. State is STALL when held && hazard.
- stall_cnt increments each cycle the stage is in STALL, saturating at 0xFFFF_FFFF.
- Operand stability: out_op1/out_op2 may change while out_valid=1 && out_ready=0. They must equal the architecturally correct value in the cycle the handshake completes. out_pc and out_rd are stable while held.
- Handshake completes with no new accept -> EMPTY. Completes with a simultaneous accept -> stays held with the new instruction.
- flush: next edge -> EMPTY regardless of in_valid; no accept that cycle (in_ready is forced 0 while flush=1).
- Unused sources (use=0) never cause hazards; their operand value is don't-care.
- rst_n asserted mid-operation: held instruction is discarded immediately; stall_cnt clears.

Decomposition:
- Shared package: XLEN and RA_W constants, the state encoding (EMPTY/FULL/STALL), and the producer-bypass record type {valid, rd, data, is_load}.
- One sub-module, operand_bypass: a purely combinational mux taking an index, rf data and three producer records, returning the resolved operand. It is instantiated twice.
- The handshake, state register and counter stay in operand_fetch.

Test Plan:
1. Reset, x3=0x55 in the register file. Accept rs1=3, rs2=0, out_ready=1 -> out_valid in the next cycle, out_op1=0x55, out_op2=0, in_ready held 1. Then stream 4 instructions -> one output per cycle.
2. Accept rs1=5 with ex_valid=1, ex_rd=5, ex_data=0xA and mem_rd=5, mem_data=0xB -> out_op1=0xA. Drop EX -> 0xB. Drop MEM, WB writes 5 with 0xC -> 0xC, then 0xC from rf after the write edge.
3. Accept rs2=7, in_use2=1, with an EX load to x7 -> out_valid=0 and stall_cnt increments for 2 cycles. The load moves to MEM with mem_data=0x99 -> out_valid=1, out_op2=0x99.
4. Producer to x0 with ex_data=0xFF, instruction reads rs1=0 -> out_op1=0 and no stall even with an EX load to x0.
5. out_ready=0 for 3 cycles while WB writes the held rs1 with 0x42 -> out_pc/out_rd stable, in_ready=0. Release -> handshake with out_op1=0x42.
6. flush while STALL -> EMPTY next cycle, out_valid=0. Assert rst_n=0 mid-hold -> out_valid drops immediately, stall_cnt=0.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared widths, stage state encoding and the producer-bypass record for operand fetch.
package operand_fetch_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
    logic            is_load;
  } byp_t;

  // x0 is hard-wired, so a producer naming it never matches.
  function automatic logic byp_hit(input byp_t p, input logic [RA_W-1:0] idx);
    return p.valid && (p.rd == idx) && (idx != '0);
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Combinational operand resolve: x0, then youngest in-flight producer (EX non-load, MEM, WB), then rf.
// Zero latency; no flow control.
module operand_bypass
  import operand_fetch_pkg::*;
(
  input  logic [RA_W-1:0] i_idx,
  input  logic [XLEN-1:0] i_rf_dat,
  input  byp_t            i_ex,
  input  byp_t            i_mem,
  input  byp_t            i_wb,
  output logic [XLEN-1:0] o_op
);

  logic w_unused;
  assign w_unused = i_mem.is_load ^ i_wb.is_load;

  always_comb begin
    o_op = i_rf_dat;
    if (i_idx == '0) begin
      o_op = '0;
    end else if (byp_hit(i_ex, i_idx) && !i_ex.is_load) begin
      o_op = i_ex.data;
    end else if (byp_hit(i_mem, i_idx)) begin
      o_op = i_mem.data;
    end else if (byp_hit(i_wb, i_idx)) begin
      o_op = i_wb.data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode->execute stage: holds one instruction across the rf read cycle, bypasses EX/MEM/WB, stalls on load-use.
// Accept at edge N gives out_valid in cycle N+1; in_ready drops while held unless the output handshake completes.
module operand_fetch #(
  parameter int XLEN = operand_fetch_pkg::XLEN,
  parameter int RA_W = operand_fetch_pkg::RA_W,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [RA_W-1:0] in_rs1,
  input  logic [RA_W-1:0] in_rs2,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_use1,
  input  logic            in_use2,
  output logic [RA_W-1:0] rf_rs1,
  output logic [RA_W-1:0] rf_rs2,
  input  logic [XLEN-1:0] rf_r1,
  input  logic [XLEN-1:0] rf_r2,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            mem_valid,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [RA_W-1:0] out_rd,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [31:0]     stall_cnt
);

  import operand_fetch_pkg::*;

  // r_state only ever holds EMPTY or FULL; STALL is the live view of a held instruction blocked this cycle.
  state_t          r_state, w_state, w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [RA_W-1:0] r_rs1, r_rs2, r_rd;
  logic            r_use1, r_use2;
  logic [31:0]     r_stall_cnt;
  logic            w_held, w_haz1, w_haz2, w_hazard, w_accept;
  byp_t            w_ex, w_mem, w_wb;

  assign w_held   = (r_state != ST_EMPTY);
  assign w_haz1   = r_use1 && (r_rs1 != '0) && ex_valid && ex_is_load && (ex_rd == r_rs1);
  assign w_haz2   = r_use2 && (r_rs2 != '0) && ex_valid && ex_is_load && (ex_rd == r_rs2);
  assign w_hazard = w_haz1 || w_haz2;

  always_comb begin
    w_state     = ST_EMPTY;
    out_valid   = 1'b0;
    in_ready    = 1'b0;
    w_accept    = 1'b0;
    w_state_nxt = r_state;
    if (w_held) begin
      w_state = w_hazard ? ST_STALL : ST_FULL;
    end
    out_valid = (w_state == ST_FULL);
    in_ready  = !flush && ((w_state == ST_EMPTY) || (out_valid && out_ready));
    w_accept  = in_valid && in_ready;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_accept) begin
      w_state_nxt = ST_FULL;
    end else if (out_valid && out_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
      r_use1 <= 1'b0;
      r_use2 <= 1'b0;
    end else if (w_accept) begin
      r_pc   <= in_pc;
      r_rs1  <= in_rs1;
      r_rs2  <= in_rs2;
      r_rd   <= in_rd;
      r_use1 <= in_use1;
      r_use2 <= in_use2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((w_state == ST_STALL) && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // Re-presenting the held index keeps the rf read data current with WB writes while we wait.
  assign rf_rs1    = in_ready ? in_rs1 : r_rs1;
  assign rf_rs2    = in_ready ? in_rs2 : r_rs2;
  assign out_pc    = r_pc;
  assign out_rd    = r_rd;
  assign stall_cnt = r_stall_cnt;

  assign w_ex  = '{valid: ex_valid,  rd: ex_rd,  data: ex_data,  is_load: ex_is_load};
  assign w_mem = '{valid: mem_valid, rd: mem_rd, data: mem_data, is_load: 1'b0};
  assign w_wb  = '{valid: wb_valid,  rd: wb_rd,  data: wb_data,  is_load: 1'b0};

  operand_bypass u_byp1 (
    .i_idx    (r_rs1),
    .i_rf_dat (rf_r1),
    .i_ex     (w_ex),
    .i_mem    (w_mem),
    .i_wb     (w_wb),
    .o_op     (out_op1)
  );

  operand_bypass u_byp2 (
    .i_idx    (r_rs2),
    .i_rf_dat (rf_r2),
    .i_ex     (w_ex),
    .i_mem    (w_mem),
    .i_wb     (w_wb),
    .o_op     (out_op2)
  );

endmodule
